phase_sequencer: RTL and testbench

//  Multi-cycle controller for the SIMPLE CPU datapath. Walks each instruction through five phases:
//  P1 fetch, P2 register read, P3 execute, P4 memory, P5 writeback/PC update.

---
 rtl/phase_sequencer_pkg.sv | 35 +++
 rtl/phase_sequencer_wait_timer.sv | 25 ++
 rtl/phase_sequencer.sv | 107 ++++++++++
 tb/tb_phase_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared encodings and helpers for the multi-cycle phase sequencer.
package phase_sequencer_pkg;

  localparam int DEF_WAIT_CYCLES = 1;
  localparam int NUM_PHASES      = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    PH_IF  = 3'd0,
    PH_RR  = 3'd1,
    PH_EX  = 3'd2,
    PH_MEM = 3'd3,
    PH_WB  = 3'd4
  } phase_e;

  function automatic phase_e next_phase(phase_e p);
    case (p)
      PH_IF:   return PH_RR;
      PH_RR:   return PH_EX;
      PH_EX:   return PH_MEM;
      PH_MEM:  return PH_WB;
      default: return PH_IF;
    endcase
  endfunction

  function automatic logic [NUM_PHASES-1:0] phase_onehot(phase_e p);
    return NUM_PHASES'(1) << p;
  endfunction

endpackage

// File: rtl/phase_sequencer_wait_timer.sv
// 4-bit loadable down-counter with a zero flag; stops at zero until reloaded.
module phase_sequencer_wait_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != 4'd0)  cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase multi-cycle controller: run/step/pause/halt FSM, phase index,
// memory wait states and retired-instruction counter.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exec_pulse,
  input  logic             step_mode,
  input  logic             halt_req,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic [4:0]       phase,
  output logic [4:0]       ph_commit,
  output logic             running,
  output logic             halted,
  output logic             mem_sel,
  output logic             mem_wren,
  output logic [CNT_W-1:0] insn_count
);

  state_e           state_q;
  phase_e           ph_q;
  logic             step_q, pause_q, halt_q;
  logic [CNT_W-1:0] cnt_q;

  logic in_run, mem_acc, wt_zero, wt_load, commit_raw, commit;

  assign in_run  = (state_q == ST_RUN);
  assign mem_acc = mem_read | mem_write;

  // Only P1 and a memory-accessing P4 wait for the timer to drain.
  always_comb begin
    commit_raw = 1'b1;
    case (ph_q)
      PH_IF:   commit_raw = wt_zero;
      PH_MEM:  commit_raw = wt_zero | ~mem_acc;
      default: commit_raw = 1'b1;
    endcase
  end

  // A reset cycle never produces a register load or RAM write.
  assign commit  = in_run & ~rst & commit_raw;
  assign wt_load = ((state_q == ST_IDLE) & exec_pulse) | commit;

  phase_sequencer_wait_timer u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wt_load),
    .load_val_i (4'(WAIT_CYCLES)),
    .zero_o     (wt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= PH_IF;
      step_q  <= 1'b0;
      pause_q <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exec_pulse) begin
            state_q <= ST_RUN;
            ph_q    <= PH_IF;
            step_q  <= step_mode;
            pause_q <= 1'b0;
            halt_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (exec_pulse) pause_q <= 1'b1;
          if (commit) begin
            if (ph_q == PH_RR) halt_q <= halt_req;
            if (ph_q == PH_WB) begin
              cnt_q   <= cnt_q + CNT_W'(1);
              ph_q    <= PH_IF;
              pause_q <= 1'b0;
              halt_q  <= 1'b0;
              // A pulse landing on this very commit still counts as a pause.
              if (halt_q)                            state_q <= ST_HALT;
              else if (step_q | pause_q | exec_pulse) state_q <= ST_IDLE;
            end else begin
              ph_q <= next_phase(ph_q);
            end
          end
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign phase      = in_run ? phase_onehot(ph_q) : 5'd0;
  assign ph_commit  = commit ? phase_onehot(ph_q) : 5'd0;
  assign mem_sel    = phase[3] & mem_acc;
  assign mem_wren   = ph_commit[3] & mem_write;
  assign running    = in_run;
  assign halted     = (state_q == ST_HALT);
  assign insn_count = cnt_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized bench for phase_sequencer: two instances (W=1/16-bit count, W=0/4-bit count)
// checked cycle by cycle against a per-instruction phase-schedule model.
module tb_phase_sequencer;

  logic clk, rst;
  logic ex[2], sm[2], hr[2], mr[2], mw[2];
  logic [4:0] ph[2], pc[2];
  logic run[2], hlt[2], msel[2], mwr[2];
  logic [15:0] cnt0;
  logic [3:0]  cnt1;

  int errors = 0, checks = 0;
  int m_cnt[2], m_st[2];      // m_st: 0 idle, 1 run, 2 halted
  bit m_step[2];

  phase_sequencer #(.WAIT_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .exec_pulse(ex[0]), .step_mode(sm[0]), .halt_req(hr[0]),
    .mem_read(mr[0]), .mem_write(mw[0]), .phase(ph[0]), .ph_commit(pc[0]),
    .running(run[0]), .halted(hlt[0]), .mem_sel(msel[0]), .mem_wren(mwr[0]),
    .insn_count(cnt0));

  phase_sequencer #(.WAIT_CYCLES(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .exec_pulse(ex[1]), .step_mode(sm[1]), .halt_req(hr[1]),
    .mem_read(mr[1]), .mem_write(mw[1]), .phase(ph[1]), .ph_commit(pc[1]),
    .running(run[1]), .halted(hlt[1]), .mem_sel(msel[1]), .mem_wren(mwr[1]),
    .insn_count(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wof(int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] exp_cnt(int d);
    return (d == 0) ? (m_cnt[d] & 32'hFFFF) : (m_cnt[d] & 32'hF);
  endfunction

  function automatic logic [31:0] cnt_of(int d);
    return (d == 0) ? {16'd0, cnt0} : {28'd0, cnt1};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle outside an instruction; pulse may start a run from idle.
  task automatic cyc_quiet(int d, bit pulse, bit step);
    ex[d] = pulse; sm[d] = step;
    hr[d] = 1'($urandom); mr[d] = 1'($urandom); mw[d] = 1'($urandom);
    @(negedge clk);
    chk("q_phase",   ph[d],   0);
    chk("q_commit",  pc[d],   0);
    chk("q_mem_sel", msel[d], 0);
    chk("q_wren",    mwr[d],  0);
    chk("q_running", run[d],  0);
    chk("q_halted",  hlt[d],  m_st[d] == 2);
    chk("q_count",   cnt_of(d), exp_cnt(d));
    @(posedge clk); #1;
    ex[d] = 1'b0;
    if (pulse && !rst && m_st[d] == 0) begin m_st[d] = 1; m_step[d] = step; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin m_st[i] = 0; m_cnt[i] = 0; end
  endtask

  // Walks one instruction from its first P1 cycle. pause_at/rst_at: cycle index or -1.
  task automatic run_insn(int d, bit rd, bit wr, bit hq, int pause_at, int rst_at);
    int w, k, len;
    bit aborted;
    w = wof(d); k = 0; aborted = 0;
    hr[d] = hq; mr[d] = rd; mw[d] = wr;
    for (int p = 0; p < 5 && !aborted; p++) begin
      len = (p == 0 || (p == 3 && (rd || wr))) ? 1 + w : 1;
      for (int c = 0; c < len && !aborted; c++) begin
        ex[d] = (k == pause_at);
        rst   = (k == rst_at);
        @(negedge clk);
        chk("phase", ph[d], 1 << p);
        if (k == rst_at) begin
          chk("rst_commit", pc[d], 0);
          chk("rst_wren",   mwr[d], 0);
        end else begin
          chk("commit", pc[d], (c == len - 1) ? (1 << p) : 0);
          chk("wren",   mwr[d], (p == 3 && c == len - 1 && wr));
        end
        chk("mem_sel", msel[d], (p == 3 && (rd || wr)));
        chk("running", run[d], 1);
        chk("count",   cnt_of(d), exp_cnt(d));
        @(posedge clk); #1;
        if (k == rst_at) aborted = 1;
        k++;
      end
    end
    ex[d] = 1'b0; rst = 1'b0; hr[d] = 1'b0; mr[d] = 1'b0; mw[d] = 1'b0;
    if (aborted) begin
      for (int i = 0; i < 2; i++) begin m_st[i] = 0; m_cnt[i] = 0; end
    end else begin
      m_cnt[d]++;
      if (hq)                              m_st[d] = 2;
      else if (m_step[d] || pause_at >= 0) m_st[d] = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ex[i] = 0; sm[i] = 0; hr[i] = 0; mr[i] = 0; mw[i] = 0;
      m_st[i] = 0; m_cnt[i] = 0; m_step[i] = 0;
    end
    @(posedge clk); #1;
    cyc_quiet(0, 0, 0);
    cyc_quiet(1, 0, 0);
    rst = 1'b0;

    // single-step ALU, then single-step store (W=1)
    cyc_quiet(0, 1, 1); run_insn(0, 0, 0, 0, -1, -1); cyc_quiet(0, 0, 0);
    cyc_quiet(0, 1, 1); run_insn(0, 0, 1, 0, -1, -1); cyc_quiet(0, 0, 0);

    // W=0 continuous run, pause requested in P3 of the 4th instruction
    cyc_quiet(1, 1, 0);
    repeat (3) run_insn(1, 0, 0, 0, -1, -1);
    run_insn(1, 0, 0, 0, 2, -1);
    cyc_quiet(1, 0, 0);

    // halt plus pause on the 2nd instruction; later pulses are ignored
    do_reset();
    cyc_quiet(0, 1, 0);
    run_insn(0, 1, 0, 0, -1, -1);
    run_insn(0, 0, 0, 1, 3, -1);
    cyc_quiet(0, 1, 0); cyc_quiet(0, 1, 1); cyc_quiet(0, 0, 0);

    // reset on the P4 commit cycle of a store, then restart
    do_reset();
    cyc_quiet(0, 1, 1); run_insn(0, 0, 1, 0, -1, 5);
    cyc_quiet(0, 0, 0);
    cyc_quiet(0, 1, 1); run_insn(0, 0, 0, 0, -1, -1); cyc_quiet(0, 0, 0);

    // counter wrap on the 4-bit instance
    do_reset();
    cyc_quiet(1, 1, 0);
    repeat (16) run_insn(1, 1'($urandom), 1'($urandom), 0, -1, -1);
    run_insn(1, 0, 0, 0, 0, -1);
    cyc_quiet(1, 0, 0);

    // randomized sessions on both instances
    for (int s = 0; s < 60; s++) begin
      int d, n, cpi, pa;
      bit rd, wr, hq;
      d = s % 2; n = 0;
      if (m_st[d] == 2) do_reset();
      cyc_quiet(d, 1, 1'($urandom));
      while (m_st[d] == 1) begin
        rd  = 1'($urandom); wr = 1'($urandom);
        hq  = ($urandom_range(0, 9) == 0);
        cpi = 5 + wof(d) + ((rd || wr) ? wof(d) : 0);
        pa  = ($urandom_range(0, 3) == 0 || n > 20) ? $urandom_range(0, cpi - 1) : -1;
        run_insn(d, rd, wr, hq, pa, -1);
        n++;
      end
      repeat ($urandom_range(1, 3)) cyc_quiet(d, (m_st[d] == 2) ? 1'($urandom) : 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
